// File: rtl/pass_scheduler.sv
// Layer pass scheduler: walks k (outer) x d (inner) tiles, issuing one PASS_START per tile with running GLB addresses.
// Optional perf counters are enabled with `define PASS_SCHED_PERF_EN.
module pass_scheduler #(
  parameter int unsigned FLAG_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  layer_start,
  input  logic [1:0]            layer_type,
  input  logic [FLAG_WIDTH-1:0] layer_flags,
  input  logic [5:0]            num_k_tiles,
  input  logic [5:0]            num_d_tiles,
  input  logic [ADDR_WIDTH-1:0] ifmap_base,
  input  logic [ADDR_WIDTH-1:0] weight_base,
  input  logic [ADDR_WIDTH-1:0] opsum_base,
  input  logic [ADDR_WIDTH-1:0] bias_base,
  input  logic [ADDR_WIDTH-1:0] ifmap_step,
  input  logic [ADDR_WIDTH-1:0] weight_step,
  input  logic [ADDR_WIDTH-1:0] opsum_step,
  input  logic [ADDR_WIDTH-1:0] bias_step,
  output logic                  PASS_START,
  output logic [1:0]            pass_layer_type,
  output logic [FLAG_WIDTH-1:0] pass_flags,
  output logic [ADDR_WIDTH-1:0] BASE_IFMAP,
  output logic [ADDR_WIDTH-1:0] BASE_WEIGHT,
  output logic [ADDR_WIDTH-1:0] BASE_OPSUM,
  output logic [ADDR_WIDTH-1:0] BASE_BIAS,
  input  logic                  pass_done,
  output logic                  layer_busy,
  output logic                  layer_done,
  output logic [5:0]            cur_k,
  output logic [5:0]            cur_d
`ifdef PASS_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_busy_cycles,
  output logic [15:0]           perf_pass_cnt
`endif
);

  localparam int unsigned TW = 6;
  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned FW = FLAG_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] cfg_nk, cfg_nd, nk_nxt, nd_nxt, k_nxt, d_nxt;
  logic [FW-1:0] cfg_flags, flags_nxt, pflags_nxt;
  logic [AW-1:0] cfg_ifmap_base, cfg_ifmap_step, cfg_weight_step, cfg_opsum_step, cfg_bias_step;
  logic [AW-1:0] ib_nxt, is_nxt, ws_nxt, os_nxt, bs_nxt;
  logic [AW-1:0] ifm_nxt, wt_nxt, ops_nxt, bias_nxt;
  logic [1:0]    ptype_nxt;
  logic          start_nxt, done_nxt, busy_nxt;
  logic          empty_c, last_c;

  // bias only on the first input-channel tile, relu only on the last
  function automatic logic [FW-1:0] pass_flag_f(input logic [FW-1:0] f, input logic [TW-1:0] d,
                                                input logic [TW-1:0] nd);
    logic [FW-1:0] r;
    r    = f;
    r[0] = f[0] & (d == TW'(0));
    r[1] = f[1] & (d == nd - TW'(1));
    return r;
  endfunction

  assign empty_c = (cfg_nk == TW'(0)) || (cfg_nd == TW'(0));
  assign last_c  = (cur_k == cfg_nk - TW'(1)) && (cur_d == cfg_nd - TW'(1));

  always_comb begin
    state_nxt  = state;
    nk_nxt     = cfg_nk;
    nd_nxt     = cfg_nd;
    flags_nxt  = cfg_flags;
    ib_nxt     = cfg_ifmap_base;
    is_nxt     = cfg_ifmap_step;
    ws_nxt     = cfg_weight_step;
    os_nxt     = cfg_opsum_step;
    bs_nxt     = cfg_bias_step;
    k_nxt      = cur_k;
    d_nxt      = cur_d;
    ifm_nxt    = BASE_IFMAP;
    wt_nxt     = BASE_WEIGHT;
    ops_nxt    = BASE_OPSUM;
    bias_nxt   = BASE_BIAS;
    pflags_nxt = pass_flags;
    ptype_nxt  = pass_layer_type;
    case (state)
      S_IDLE: begin
        if (layer_start) begin
          nk_nxt     = num_k_tiles;
          nd_nxt     = num_d_tiles;
          flags_nxt  = layer_flags;
          ib_nxt     = ifmap_base;
          is_nxt     = ifmap_step;
          ws_nxt     = weight_step;
          os_nxt     = opsum_step;
          bs_nxt     = bias_step;
          k_nxt      = TW'(0);
          d_nxt      = TW'(0);
          ifm_nxt    = ifmap_base;
          wt_nxt     = weight_base;
          ops_nxt    = opsum_base;
          bias_nxt   = bias_base;
          pflags_nxt = pass_flag_f(layer_flags, TW'(0), num_d_tiles);
          ptype_nxt  = layer_type;
          // an empty layer goes via NEXT so its done latency matches a normal layer's
          if ((num_k_tiles == TW'(0)) || (num_d_tiles == TW'(0))) state_nxt = S_NEXT;
          else state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (pass_done) state_nxt = S_NEXT;
      S_NEXT: begin
        if (empty_c || last_c) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_ISSUE;
          wt_nxt    = BASE_WEIGHT + cfg_weight_step;
          if (cur_d < cfg_nd - TW'(1)) begin
            d_nxt   = cur_d + TW'(1);
            ifm_nxt = BASE_IFMAP + cfg_ifmap_step;
          end else begin
            d_nxt    = TW'(0);
            k_nxt    = cur_k + TW'(1);
            ifm_nxt  = cfg_ifmap_base;
            ops_nxt  = BASE_OPSUM + cfg_opsum_step;
            bias_nxt = BASE_BIAS + cfg_bias_step;
          end
          pflags_nxt = pass_flag_f(cfg_flags, d_nxt, cfg_nd);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    start_nxt = (state_nxt == S_ISSUE);
    done_nxt  = (state_nxt == S_DONE);
    busy_nxt  = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      cfg_nk          <= '0;
      cfg_nd          <= '0;
      cfg_flags       <= '0;
      cfg_ifmap_base  <= '0;
      cfg_ifmap_step  <= '0;
      cfg_weight_step <= '0;
      cfg_opsum_step  <= '0;
      cfg_bias_step   <= '0;
      cur_k           <= '0;
      cur_d           <= '0;
      BASE_IFMAP      <= '0;
      BASE_WEIGHT     <= '0;
      BASE_OPSUM      <= '0;
      BASE_BIAS       <= '0;
      pass_flags      <= '0;
      pass_layer_type <= '0;
      PASS_START      <= 1'b0;
      layer_done      <= 1'b0;
      layer_busy      <= 1'b0;
    end else begin
      state           <= state_nxt;
      cfg_nk          <= nk_nxt;
      cfg_nd          <= nd_nxt;
      cfg_flags       <= flags_nxt;
      cfg_ifmap_base  <= ib_nxt;
      cfg_ifmap_step  <= is_nxt;
      cfg_weight_step <= ws_nxt;
      cfg_opsum_step  <= os_nxt;
      cfg_bias_step   <= bs_nxt;
      cur_k           <= k_nxt;
      cur_d           <= d_nxt;
      BASE_IFMAP      <= ifm_nxt;
      BASE_WEIGHT     <= wt_nxt;
      BASE_OPSUM      <= ops_nxt;
      BASE_BIAS       <= bias_nxt;
      pass_flags      <= pflags_nxt;
      pass_layer_type <= ptype_nxt;
      PASS_START      <= start_nxt;
      layer_done      <= done_nxt;
      layer_busy      <= busy_nxt;
    end
  end

`ifdef PASS_SCHED_PERF_EN
  // saturating counters, cleared when a new layer is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_busy_cycles <= '0;
      perf_pass_cnt    <= '0;
    end else if ((state == S_IDLE) && layer_start) begin
      perf_busy_cycles <= '0;
      perf_pass_cnt    <= '0;
    end else begin
      if (layer_busy && !(&perf_busy_cycles)) perf_busy_cycles <= perf_busy_cycles + 32'(1);
      if (PASS_START && !(&perf_pass_cnt))    perf_pass_cnt    <= perf_pass_cnt + 16'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pass_scheduler.sv
// Scoreboard bench for pass_scheduler: stimulus pushes expected pass/done events, a negedge monitor pops and compares.
module tb_pass_scheduler;
  localparam int unsigned FW = 4;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          layer_start = 1'b0;
  logic [1:0]    layer_type = '0;
  logic [FW-1:0] layer_flags = '0;
  logic [5:0]    num_k_tiles = '0, num_d_tiles = '0;
  logic [AW-1:0] ifmap_base = '0, weight_base = '0, opsum_base = '0, bias_base = '0;
  logic [AW-1:0] ifmap_step = '0, weight_step = '0, opsum_step = '0, bias_step = '0;
  logic          pass_done = 1'b0;
  logic          PASS_START, layer_busy, layer_done;
  logic [1:0]    pass_layer_type;
  logic [FW-1:0] pass_flags;
  logic [AW-1:0] BASE_IFMAP, BASE_WEIGHT, BASE_OPSUM, BASE_BIAS;
  logic [5:0]    cur_k, cur_d;
`ifdef PASS_SCHED_PERF_EN
  logic [31:0]   perf_busy_cycles;
  logic [15:0]   perf_pass_cnt;
`endif

  pass_scheduler #(.FLAG_WIDTH(FW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .layer_start(layer_start), .layer_type(layer_type),
    .layer_flags(layer_flags), .num_k_tiles(num_k_tiles), .num_d_tiles(num_d_tiles),
    .ifmap_base(ifmap_base), .weight_base(weight_base), .opsum_base(opsum_base), .bias_base(bias_base),
    .ifmap_step(ifmap_step), .weight_step(weight_step), .opsum_step(opsum_step), .bias_step(bias_step),
    .PASS_START(PASS_START), .pass_layer_type(pass_layer_type), .pass_flags(pass_flags),
    .BASE_IFMAP(BASE_IFMAP), .BASE_WEIGHT(BASE_WEIGHT), .BASE_OPSUM(BASE_OPSUM), .BASE_BIAS(BASE_BIAS),
    .pass_done(pass_done), .layer_busy(layer_busy), .layer_done(layer_done),
    .cur_k(cur_k), .cur_d(cur_d)
`ifdef PASS_SCHED_PERF_EN
    , .perf_busy_cycles(perf_busy_cycles), .perf_pass_cnt(perf_pass_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_passed = 0;
  logic [127:0] exp_q[$];

  typedef struct {
    int nk; int nd;
    logic [3:0] fl; logic [1:0] ty;
    logic [15:0] ib, wb, ob, bb, istep, wstep, ostep, bstep;
  } cfg_t;

  function automatic logic [127:0] mk_pass(int c, logic [5:0] k, logic [5:0] d, logic [15:0] ifm,
                                           logic [15:0] wt, logic [15:0] ops, logic [15:0] bias,
                                           logic [3:0] fl, logic [1:0] ty, logic busy);
    return 128'({1'b0, 32'(c), k, d, ifm, wt, ops, bias, fl, ty, busy});
  endfunction

  function automatic logic [127:0] mk_done(int c);
    return 128'({1'b1, 83'd0, 32'(c)});
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_passed++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic pop_check(input string name, input logic [127:0] got);
    logic [127:0] want;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s unexpected: got %h want no event", name, got);
    end else begin
      want = exp_q.pop_front();
      check(name, got, want);
    end
  endtask

  // monitor: every PASS_START / layer_done must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (PASS_START)
        pop_check("pass", mk_pass(cyc, cur_k, cur_d, BASE_IFMAP, BASE_WEIGHT, BASE_OPSUM, BASE_BIAS,
                                  pass_flags, pass_layer_type, layer_busy));
      if (layer_done) pop_check("layer_done", mk_done(cyc));
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // starts a layer in the current cycle; pass_done returns 5 cycles after each PASS_START.
  // n_abort>0: expect only that many passes and stop in WAIT of the last one.
  task automatic run_layer(input cfg_t c, input bit extra, input int n_abort);
    int t0, n, n_run, n_ack, t_end, kk, dd;
    logic [15:0] ifm, wt, ops, bias;
    logic [3:0] fl;
    t0 = cyc;
    num_k_tiles = 6'(c.nk); num_d_tiles = 6'(c.nd); layer_flags = c.fl; layer_type = c.ty;
    ifmap_base = c.ib; weight_base = c.wb; opsum_base = c.ob; bias_base = c.bb;
    ifmap_step = c.istep; weight_step = c.wstep; opsum_step = c.ostep; bias_step = c.bstep;
    layer_start = 1'b1;
    n = c.nk * c.nd;
    n_run = (n_abort > 0) ? n_abort : n;
    n_ack = (n_abort > 0) ? n_run - 1 : n_run;
    for (int i = 0; i < n_run; i++) begin
      kk   = i / c.nd;
      dd   = i % c.nd;
      ifm  = c.ib + 16'(dd) * c.istep;
      wt   = c.wb + 16'(kk * c.nd + dd) * c.wstep;
      ops  = c.ob + 16'(kk) * c.ostep;
      bias = c.bb + 16'(kk) * c.bstep;
      fl   = {c.fl[3:2], c.fl[1] & (dd == c.nd - 1), c.fl[0] & (dd == 0)};
      exp_q.push_back(mk_pass(t0 + 1 + 7 * i, 6'(kk), 6'(dd), ifm, wt, ops, bias, fl, c.ty, 1'b1));
    end
    if (n_abort > 0) t_end = t0 + 1 + 7 * (n_run - 1) + 2;
    else if (n == 0) t_end = t0 + 2;
    else t_end = t0 + 1 + 7 * n;
    if (n_abort == 0) exp_q.push_back(mk_done(t_end));
    for (int cc = t0 + 1; cc <= t_end; cc++) begin
      goto(cc);
      layer_start = extra && (cc == t0 + 3 || cc == t0 + 13);
      pass_done = extra && (cc == t0 + 1);
      for (int i = 0; i < n_ack; i++) if (cc == t0 + 6 + 7 * i) pass_done = 1'b1;
      if (extra) begin
        num_k_tiles = 6'd5; num_d_tiles = 6'd5; layer_flags = 4'h0; layer_type = 2'd3;
        ifmap_base = 16'hAAAA; weight_base = 16'hAAAA; opsum_base = 16'hAAAA; bias_base = 16'hAAAA;
        ifmap_step = 16'h5555; weight_step = 16'h5555; opsum_step = 16'h5555; bias_step = 16'h5555;
      end
    end
    if (n_abort == 0) begin
      goto(t_end + 1);
      layer_start = 1'b0;
      pass_done = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " PASS_START"}, 128'(PASS_START), 128'(0));
    check({tag, " layer_done"}, 128'(layer_done), 128'(0));
    check({tag, " layer_busy"}, 128'(layer_busy), 128'(0));
    check({tag, " cur_k/cur_d"}, 128'({cur_k, cur_d}), 128'(0));
    check({tag, " BASE_*"}, 128'({BASE_IFMAP, BASE_WEIGHT, BASE_OPSUM, BASE_BIAS}), 128'(0));
    check({tag, " flags/type"}, 128'({pass_flags, pass_layer_type}), 128'(0));
  endtask

  cfg_t cfg_a, cfg_b, cfg_e0, cfg_e1, cfg_c, cfg_d;

  initial begin
    cfg_a  = '{nk: 2, nd: 3, fl: 4'b1011, ty: 2'd2, ib: 16'h0, wb: 16'h0, ob: 16'h0, bb: 16'h0,
               istep: 16'h40, wstep: 16'h10, ostep: 16'h100, bstep: 16'h4};
    cfg_b  = '{nk: 1, nd: 2, fl: 4'b0111, ty: 2'd1, ib: 16'hFFF0, wb: 16'hFFFF, ob: 16'h1234, bb: 16'h10,
               istep: 16'h20, wstep: 16'h1, ostep: 16'h8, bstep: 16'h2};
    cfg_e0 = '{nk: 3, nd: 0, fl: 4'b0011, ty: 2'd1, ib: 16'h10, wb: 16'h20, ob: 16'h30, bb: 16'h40,
               istep: 16'h1, wstep: 16'h1, ostep: 16'h1, bstep: 16'h1};
    cfg_e1 = '{nk: 0, nd: 4, fl: 4'b0011, ty: 2'd0, ib: 16'h10, wb: 16'h20, ob: 16'h30, bb: 16'h40,
               istep: 16'h1, wstep: 16'h1, ostep: 16'h1, bstep: 16'h1};
    cfg_c  = '{nk: 2, nd: 2, fl: 4'b0011, ty: 2'd3, ib: 16'h100, wb: 16'h200, ob: 16'h300, bb: 16'h400,
               istep: 16'h8, wstep: 16'h8, ostep: 16'h8, bstep: 16'h8};
    cfg_d  = '{nk: 1, nd: 1, fl: 4'b1111, ty: 2'd2, ib: 16'h0A00, wb: 16'h0B00, ob: 16'h0C00, bb: 16'h0D00,
               istep: 16'h1, wstep: 16'h1, ostep: 16'h1, bstep: 16'h1};

    #1 rst = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    goto(cyc + 2);

    // stray pass_done while idle must not start anything
    pass_done = 1'b1;
    goto(cyc + 1);
    pass_done = 1'b0;
    goto(cyc + 2);

    run_layer(cfg_a, 1'b0, 0);
`ifdef PASS_SCHED_PERF_EN
    check("perf_pass_cnt", 128'(perf_pass_cnt), 128'(6));
    check("perf_busy_cycles", 128'(perf_busy_cycles), 128'(43));
`endif
    goto(cyc + 3);
    run_layer(cfg_b, 1'b1, 0);
    goto(cyc + 2);
    run_layer(cfg_e0, 1'b0, 0);
    goto(cyc + 2);
    run_layer(cfg_e1, 1'b0, 0);
    goto(cyc + 2);

    // reset in WAIT of the third pass aborts the layer immediately
    run_layer(cfg_c, 1'b0, 3);
    #3 rst = 1'b0;
    #1 check_all_zero("abort");
    check("abort scoreboard drained", 128'(exp_q.size()), 128'(0));
    goto(cyc + 3);
    rst = 1'b1;
    goto(cyc + 4);
    check("post-reset idle busy", 128'({layer_busy, PASS_START}), 128'(0));
    run_layer(cfg_d, 1'b0, 0);

    goto(cyc + 5);
    check("final scoreboard drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
